rsa_modexp_engine: RTL and testbench

- Computes RSA encryption `result = plain_text^exponent mod modulus` using bit-serial Montgomery multiplication.
- Sits directly downstream of the RSA peripheral register file. It consumes the command, plain-text, exponent, modulus and Montgomery-constant registers, and it drives the encrypted-data and status read-back registers.
- Uses a square-and-always-multiply ladder, so latency is constant by default.

---
 rtl/rsa_modexp_engine_if.sv | 26 ++
 rtl/rsa_modexp_engine.sv | 193 +++++++++++++++++++
 tb/tb_rsa_modexp_engine.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/rsa_modexp_engine_if.sv
// Register-file side bundle of the RSA modular-exponentiation engine:
// command bits, operands, and the result/status read-back.
interface rsa_modexp_engine_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] plain_text;
    logic [WIDTH-1:0] exponent;
    logic [WIDTH-1:0] modulus;
    logic [WIDTH-1:0] mont_const;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic             error;

    modport master (
        output start, stop, plain_text, exponent, modulus, mont_const,
        input  result, busy, done, error
    );

    modport slave (
        input  start, stop, plain_text, exponent, modulus, mont_const,
        output result, busy, done, error
    );
endinterface

// File: rtl/rsa_modexp_engine.sv
// result = plain_text^exponent mod modulus via bit-serial Montgomery multiply.
// Define RSA_SKIP_DUMMY_MULT_EN to skip MULT steps on zero exponent bits.
module rsa_modexp_engine #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    rsa_modexp_engine_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_MONT_M, S_MONT_ONE, S_SQUARE, S_MULT, S_FROM_MONT, S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic             start_q, start_d;
    logic [WIDTH-1:0] m_q, m_d, e_q, e_d, n_q, n_d, r2_q, r2_d;
    logic [WIDTH-1:0] mb_q, mb_d, a_q, a_d;
    logic [WIDTH+1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d, done_q, done_d, error_q, error_d;

    logic [WIDTH-1:0] x_src, y_src, mm_res;
    logic [WIDTH+1:0] acc_add, acc_odd, acc_step, n_ext;
    logic             x_bit, e_bit, launch;
    state_e           after_bit;

    // Operand routing for the multiply in flight; a_q stays stable until write-back.
    // NOTE: every signal assigned in a combinational block gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        x_src = a_q;
        y_src = a_q;
        case (state_q)
            S_MONT_M:    begin x_src = m_q; y_src = r2_q; end
            S_MONT_ONE:  begin x_src = ONE; y_src = r2_q; end
            S_MULT:      y_src = mb_q;
            S_FROM_MONT: y_src = ONE;
            default:     ;
        endcase
    end

    assign n_ext    = {2'b00, n_q};
    assign x_bit    = |(x_src & (ONE << cnt_q));
    assign e_bit    = |(e_q & (ONE << bit_q));
    assign acc_add  = acc_q + (x_bit ? {2'b00, y_src} : '0);
    assign acc_odd  = acc_add + (acc_add[0] ? n_ext : '0);
    assign acc_step = acc_odd >> 1;
    // Accumulator stays below 2n, so one conditional subtract fully reduces it.
    assign mm_res   = WIDTH'((acc_q >= n_ext) ? acc_q - n_ext : acc_q);
    assign launch   = bus.start & ~start_q & ~bus.stop;
    assign after_bit = (bit_q == '0) ? S_FROM_MONT : S_SQUARE;

    always_comb begin
        state_d  = state_q;
        start_d  = bus.start;
        m_d      = m_q;
        e_d      = e_q;
        n_d      = n_q;
        r2_d     = r2_q;
        mb_d     = mb_q;
        a_d      = a_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = done_q;
        error_d  = error_q;

        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    m_d     = bus.plain_text;
                    e_d     = bus.exponent;
                    n_d     = bus.modulus;
                    r2_d    = bus.mont_const;
                    acc_d   = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    if (!bus.modulus[0]) begin
                        error_d  = 1'b1;
                        done_d   = 1'b1;
                        result_d = '0;
                        state_d  = S_DONE;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = S_MONT_M;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                if (cnt_q != CW'(WIDTH)) begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    acc_d = '0;
                    cnt_d = '0;
                    if (state_q != S_SQUARE) bit_d = (bit_q == '0) ? bit_q : bit_q - BW'(1);
                    case (state_q)
                        S_MONT_M: begin
                            mb_d    = mm_res;
                            state_d = S_MONT_ONE;
                        end
                        S_MONT_ONE: begin
                            a_d     = mm_res;
                            bit_d   = BW'(WIDTH - 1);
                            state_d = S_SQUARE;
                        end
                        S_SQUARE: begin
                            a_d     = mm_res;
                            state_d = S_MULT;
`ifdef RSA_SKIP_DUMMY_MULT_EN
                            if (!e_bit) begin
                                state_d = after_bit;
                                bit_d   = (bit_q == '0) ? bit_q : bit_q - BW'(1);
                            end
`endif
                        end
                        S_MULT: begin
                            if (e_bit) a_d = mm_res;
                            state_d = after_bit;
                        end
                        default: begin
                            result_d = mm_res;
                            done_d   = 1'b1;
                            busy_d   = 1'b0;
                            state_d  = S_DONE;
                        end
                    endcase
                end
            end
        endcase

        // Abort wins over everything, including a simultaneous start edge.
        if (bus.stop) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            error_d = 1'b0;
            acc_d   = '0;
            cnt_d   = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    // NOTE: operand and intermediate registers are always written before use
    // after a launch, so they carry no reset.
    always_ff @(posedge clk) begin
        m_q  <= m_d;
        e_q  <= e_d;
        n_q  <= n_d;
        r2_q <= r2_d;
        mb_q <= mb_d;
        a_q  <= a_d;
        bit_q <= bit_d;
    end

    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.error  = error_q;
endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Self-checking bench for rsa_modexp_engine: directed boundary cases plus
// randomized operands checked against a plain-arithmetic modexp model.
module tb_rsa_modexp_engine;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    rsa_modexp_engine_if #(.WIDTH(W)) bus ();

    rsa_modexp_engine #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Right-to-left square-and-multiply with ordinary integer arithmetic.
    function automatic int unsigned ref_modexp(int unsigned m, int unsigned e, int unsigned n);
        int unsigned r = 1 % n;
        int unsigned b = m % n;
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * b) % n;
            b = (b * b) % n;
        end
        return r;
    endfunction

    function automatic int unsigned ref_latency(logic [W-1:0] e);
`ifdef RSA_SKIP_DUMMY_MULT_EN
        return (W + 3 + $countones(e)) * (W + 1);
`else
        return (2 * W + 3) * (W + 1);
`endif
    endfunction

    task automatic drive_ops(input logic [W-1:0] m, e, n, rc);
        bus.plain_text = m;
        bus.exponent   = e;
        bus.modulus    = n;
        bus.mont_const = rc;
    endtask

    // Full launch-to-done transaction with latency, result and status checks.
    task automatic run_op(input string tag, input logic [W-1:0] m, e, n, rc, input bit toggle);
        int unsigned exp_r = ref_modexp(m, e, n);
        int unsigned lat   = 0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        drive_ops(m, e, n, rc);
        bus.start = 1'b1;
        @(negedge clk);
        check({tag, " busy_after_launch"}, bus.busy, 1);
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (cyc == 2) drive_ops(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
            if (toggle && cyc == 20) bus.start = 1'b0;
            if (toggle && cyc == 21) bus.start = 1'b1;
            if (bus.done) begin
                lat = cyc;
                break;
            end
        end
        check({tag, " latency"}, lat, ref_latency(e));
        check({tag, " result"}, bus.result, exp_r);
        check({tag, " busy_at_done"}, bus.busy, 0);
        check({tag, " error_at_done"}, bus.error, 0);
        check({tag, " result_lt_n"}, 32'(bus.result < n), 1);
        bus.start = 1'b0;
    endtask

    initial begin
        int unsigned n_r;
        int          busy_seen;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        drive_ops('0, '0, '0, '0);
        repeat (3) @(negedge clk);
        check("reset result", bus.result, 0);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset error", bus.error, 0);
        rst_n = 1'b1;

        run_op("n33", 8'd4, 8'd7, 8'd33, 8'd31, 1'b0);
        run_op("n255", 8'd254, 8'd255, 8'd255, 8'd1, 1'b0);
        run_op("e0", 8'd200, 8'd0, 8'd251, 8'd25, 1'b0);
        run_op("n1", 8'd0, 8'd5, 8'd1, 8'd0, 1'b0);

        // Even modulus: immediate error completion, no busy phase.
        @(negedge clk);
        drive_ops(8'd9, 8'd3, 8'd32, 8'd0);
        bus.start = 1'b1;
        @(negedge clk);
        check("even done", bus.done, 1);
        check("even error", bus.error, 1);
        check("even result", bus.result, 0);
        busy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.busy) busy_seen++;
            @(negedge clk);
        end
        check("even busy_never", busy_seen, 0);
        check("even done_sticky", bus.done, 1);
        bus.start = 1'b0;
        run_op("after_even", 8'd4, 8'd7, 8'd33, 8'd31, 1'b0);

        // Abort mid-operation; result must keep 16 from the previous run.
        @(negedge clk);
        drive_ops(8'd5, 8'd7, 8'd33, 8'd31);
        bus.start = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc < 50; cyc++) @(negedge clk);
        bus.stop = 1'b1;
        @(negedge clk);
        check("stop busy", bus.busy, 0);
        check("stop done", bus.done, 0);
        check("stop result_kept", bus.result, 16);
        bus.stop = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.busy || bus.done) busy_seen++;
        end
        check("stop no_relaunch", busy_seen, 0);
        bus.start = 1'b0;
        run_op("after_stop", 8'd5, 8'd7, 8'd33, 8'd31, 1'b0);

        // start and stop rising together: no launch.
        @(negedge clk);
        bus.stop  = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        check("start_stop busy", bus.busy, 0);
        bus.stop  = 1'b0;
        bus.start = 1'b0;

        // Reset in the middle of an operation.
        @(negedge clk);
        drive_ops(8'd4, 8'd7, 8'd33, 8'd31);
        bus.start = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc < 100; cyc++) @(negedge clk);
        rst_n = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("midrst result", bus.result, 0);
        check("midrst busy", bus.busy, 0);
        check("midrst done", bus.done, 0);
        check("midrst error", bus.error, 0);
        rst_n = 1'b1;
        run_op("after_rst", 8'd4, 8'd7, 8'd33, 8'd31, 1'b0);

        // Randomized odd moduli; some runs toggle start while busy.
        for (int k = 0; k < 16; k++) begin
            n_r = ($urandom_range(0, 255) | 1);
            run_op($sformatf("rand%0d", k), W'($urandom), W'($urandom), W'(n_r),
                   W'((1 << (2 * W)) % n_r), 1'(k % 3 == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
